anim_sequencer: RTL and testbench

//   Frame-step generator that sits directly upstream of the animation sprite memory.

---
 rtl/anim_pkg.sv | 28 ++
 rtl/anim_hold_timer.sv | 53 +++++
 rtl/anim_sequencer.sv | 174 +++++++++++++++++
 tb/tb_anim_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/anim_pkg.sv
// ============================================================================
// Module : anim_pkg
// Brief  : Shared types and defaults for the animation frame sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package anim_pkg;

  localparam int ANIM_FRAMES = 16;
  localparam int ANIM_STEP_W = 4;
  localparam int ANIM_HOLD_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } anim_state_e;

  typedef enum logic [0:0] {
    FWD = 1'b0,
    REV = 1'b1
  } anim_dir_e;

endpackage

`default_nettype wire

// File: rtl/anim_hold_timer.sv
// ============================================================================
// Module : anim_hold_timer
// Brief  : Per-frame hold counter; frame_tick marks the last tick of a frame.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module anim_hold_timer #(
  parameter int HOLD_W = 4
) (
  input  logic              clk_24,
  input  logic              rst,
  input  logic              load,
  input  logic              run,
  input  logic [HOLD_W-1:0] hold_len,
  output logic              frame_tick
);

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  assign frame_tick = run & (hold_cnt_q == hold_q);

  // hold_len is captured only at frame start, so mid-frame edits wait a frame.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    hold_d     = hold_q;
    if (load) begin
      hold_cnt_d = '0;
      hold_d     = hold_len;
    end else if (run) begin
      if (frame_tick) begin
        hold_cnt_d = '0;
        hold_d     = hold_len;
      end else begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      end
    end
  end

  always_ff @(posedge clk_24 or posedge rst) begin
    if (rst) begin
      hold_cnt_q <= '0;
      hold_q     <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      hold_q     <= hold_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/anim_sequencer.sv
// ============================================================================
// Module : anim_sequencer
// Brief  : Frame-step generator for the sprite memory (play/pause, loop,
//          one-shot, per-frame hold). ANIM_PINGPONG_EN adds bounce mode.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module anim_sequencer
  import anim_pkg::*;
#(
  parameter int FRAMES = ANIM_FRAMES,
  parameter int STEP_W = ANIM_STEP_W,
  parameter int HOLD_W = ANIM_HOLD_W
) (
  input  logic              clk_24,
  input  logic              rst,
  input  logic              play,
  input  logic              restart,
  input  logic              loop_en,
  input  logic              pingpong,
  input  logic [HOLD_W-1:0] hold_len,
  output logic [STEP_W-1:0] step,
  output logic              busy,
  output logic              wrap,
  output logic              done
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(FRAMES - 1);

  anim_state_e       state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              busy_q, busy_d;
  logic              wrap_q, wrap_d;
  logic              done_q, done_d;

  logic frame_tick;
  logic timer_load;
  logic timer_run;
  logic at_rev;
  logic pp_on;
  logic set_fwd;
  logic set_rev;

  assign timer_load = restart | ((state_q == IDLE) & play);
  assign timer_run  = (state_q == PLAY);

  anim_hold_timer #(
    .HOLD_W (HOLD_W)
  ) u_hold_timer (
    .clk_24     (clk_24),
    .rst        (rst),
    .load       (timer_load),
    .run        (timer_run),
    .hold_len   (hold_len),
    .frame_tick (frame_tick)
  );

`ifdef ANIM_PINGPONG_EN
  anim_dir_e dir_q, dir_d;

  assign at_rev = (dir_q == REV);
  assign pp_on  = pingpong;

  always_comb begin
    dir_d = dir_q;
    if (set_fwd) begin
      dir_d = FWD;
    end else if (set_rev) begin
      dir_d = REV;
    end
  end

  always_ff @(posedge clk_24 or posedge rst) begin
    if (rst) begin
      dir_q <= FWD;
    end else begin
      dir_q <= dir_d;
    end
  end
`else
  logic unused_pp;

  assign at_rev    = 1'b0;
  assign pp_on     = 1'b0;
  assign unused_pp = pingpong ^ set_fwd ^ set_rev;
`endif

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    set_fwd = 1'b0;
    set_rev = 1'b0;
    if (restart) begin
      step_d  = '0;
      set_fwd = 1'b1;
      state_d = play ? PLAY : IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          step_d = '0;
          if (play) state_d = PLAY;
        end
        PLAY: begin
          // A falling play still lets this tick's advance complete.
          if (!play) state_d = PAUSE;
          if (frame_tick) begin
            if (at_rev) begin
              if (step_q == '0) begin
                step_d  = STEP_W'(1);
                set_fwd = 1'b1;
                wrap_d  = 1'b1;
              end else begin
                step_d = step_q - STEP_W'(1);
              end
            end else if (step_q == LAST_STEP) begin
              if (loop_en) begin
                wrap_d = 1'b1;
                if (pp_on) begin
                  step_d  = LAST_STEP - STEP_W'(1);
                  set_rev = 1'b1;
                end else begin
                  step_d = '0;
                end
              end else begin
                state_d = DONE;
                done_d  = 1'b1;
              end
            end else begin
              step_d = step_q + STEP_W'(1);
            end
          end
        end
        PAUSE: begin
          if (play) state_d = PLAY;
        end
        DONE: begin
          step_d = LAST_STEP;
        end
        default: begin
          state_d = IDLE;
          step_d  = '0;
        end
      endcase
    end
    busy_d = (state_d == PLAY) | (state_d == PAUSE);
  end

  always_ff @(posedge clk_24 or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign step = step_q;
  assign busy = busy_q;
  assign wrap = wrap_q;
  assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_anim_sequencer.sv
// ============================================================================
// Module : tb_anim_sequencer
// Brief  : Scoreboard bench driving three sequencers (16, 10 and 4 frames)
//          from shared stimulus; honours ANIM_PINGPONG_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_anim_sequencer;

`ifdef ANIM_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  localparam int S_IDLE  = 0;
  localparam int S_PLAY  = 1;
  localparam int S_PAUSE = 2;
  localparam int S_DONE  = 3;

  logic       clk_24   = 1'b0;
  logic       rst      = 1'b0;
  logic       play     = 1'b0;
  logic       restart  = 1'b0;
  logic       loop_en  = 1'b0;
  logic       pingpong = 1'b0;
  logic [3:0] hold_len = 4'd0;

  logic [3:0] step_a, step_b, step_c;
  logic       busy_a, busy_b, busy_c;
  logic       wrap_a, wrap_b, wrap_c;
  logic       done_a, done_b, done_c;

  anim_sequencer #(.FRAMES(16), .STEP_W(4), .HOLD_W(4)) u_dut_a (
    .clk_24(clk_24), .rst(rst), .play(play), .restart(restart), .loop_en(loop_en),
    .pingpong(pingpong), .hold_len(hold_len), .step(step_a), .busy(busy_a),
    .wrap(wrap_a), .done(done_a));

  anim_sequencer #(.FRAMES(10), .STEP_W(4), .HOLD_W(4)) u_dut_b (
    .clk_24(clk_24), .rst(rst), .play(play), .restart(restart), .loop_en(loop_en),
    .pingpong(pingpong), .hold_len(hold_len), .step(step_b), .busy(busy_b),
    .wrap(wrap_b), .done(done_b));

  anim_sequencer #(.FRAMES(4), .STEP_W(4), .HOLD_W(4)) u_dut_c (
    .clk_24(clk_24), .rst(rst), .play(play), .restart(restart), .loop_en(loop_en),
    .pingpong(pingpong), .hold_len(hold_len), .step(step_c), .busy(busy_c),
    .wrap(wrap_c), .done(done_c));

  always #5 clk_24 = ~clk_24;

  typedef struct {
    int state;
    int step;
    int cnt;
    int hq;
    int dir;
    bit busy;
    bit wrap;
    bit done;
  } m_t;

  m_t          mdl [3];
  int          frames_tab [3] = '{16, 10, 4};
  logic [20:0] exp_q [$];
  logic [20:0] expv;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_done;

  wire [20:0] obs = {step_a, busy_a, wrap_a, done_a,
                     step_b, busy_b, wrap_b, done_b,
                     step_c, busy_c, wrap_c, done_c};

  function automatic m_t mdl_reset();
    m_t r;
    r.state = S_IDLE; r.step = 0; r.cnt = 0; r.hq = 0; r.dir = 0;
    r.busy = 1'b0; r.wrap = 1'b0; r.done = 1'b0;
    return r;
  endfunction

  // Reference behaviour written directly from the frame-advance rules.
  function automatic m_t mdl_next(m_t m, int frames);
    m_t n = m;
    n.wrap = 1'b0;
    n.done = 1'b0;
    if (restart) begin
      n.step = 0; n.cnt = 0; n.dir = 0; n.hq = int'(hold_len);
      n.state = play ? S_PLAY : S_IDLE;
    end else if (m.state == S_IDLE) begin
      if (play) begin
        n.state = S_PLAY; n.cnt = 0; n.hq = int'(hold_len);
      end
    end else if (m.state == S_PLAY) begin
      if (!play) n.state = S_PAUSE;
      if (m.cnt == m.hq) begin
        n.cnt = 0;
        n.hq  = int'(hold_len);
        if (PP && m.dir == 1) begin
          if (m.step == 0) begin n.dir = 0; n.step = 1; n.wrap = 1'b1; end
          else n.step = m.step - 1;
        end else if (m.step == frames - 1) begin
          if (loop_en) begin
            n.wrap = 1'b1;
            if (PP && pingpong) begin n.dir = 1; n.step = frames - 2; end
            else n.step = 0;
          end else begin
            n.state = S_DONE; n.done = 1'b1;
          end
        end else begin
          n.step = m.step + 1;
        end
      end else begin
        n.cnt = m.cnt + 1;
      end
    end else if (m.state == S_PAUSE) begin
      if (play) n.state = S_PLAY;
    end
    n.busy = (n.state == S_PLAY) || (n.state == S_PAUSE);
    return n;
  endfunction

  function automatic logic [6:0] pk(m_t m);
    logic [31:0] s = m.step;
    return {s[3:0], m.busy, m.wrap, m.done};
  endfunction

  function automatic logic [20:0] pk_all();
    return {pk(mdl[0]), pk(mdl[1]), pk(mdl[2])};
  endfunction

  // Steps the model with the inputs present before the edge, then clocks the DUT.
  task automatic advance();
    for (int i = 0; i < 3; i++) begin
      if (rst) mdl[i] = mdl_reset();
      else     mdl[i] = mdl_next(mdl[i], frames_tab[i]);
    end
    exp_q.push_back(pk_all());
    @(posedge clk_24);
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) mdl[i] = mdl_reset();
    @(posedge clk_24); #1;
    n_checks++;
    if (obs !== pk_all()) begin
      n_fail++; $display("FAIL reset_state: got %h required %h", obs, pk_all());
    end
    rst = 1'b0; play = 1'b1; loop_en = 1'b1; hold_len = 4'd0;
    for (int c = 0; c < 8; c++) begin
      advance();
      expv = exp_q.pop_front();
      n_checks++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL reset_run cyc %0d: got %h required %h", c, obs, expv);
      end
    end
    n_checks++;
    if (step_a !== 4'd7) begin
      n_fail++; $display("FAIL reset_pre_step: got %0d required 7", step_a);
    end
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) mdl[i] = mdl_reset();
    n_checks++;
    if (obs !== pk_all()) begin
      n_fail++; $display("FAIL reset_async: got %h required %h", obs, pk_all());
    end
    @(posedge clk_24); #1;
    rst = 1'b0;
  endtask

  task automatic test_hold();
    hold_len = 4'd2; play = 1'b1; loop_en = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c == 7) hold_len = 4'd0;
      advance();
      expv = exp_q.pop_front();
      n_checks++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL hold cyc %0d: got %h required %h", c, obs, expv);
      end
    end
  endtask

  task automatic test_one_shot();
    hold_len = 4'd0; loop_en = 1'b0; play = 1'b1; restart = 1'b1;
    n_done = 0;
    for (int c = 0; c < 22; c++) begin
      advance();
      restart = 1'b0;
      expv = exp_q.pop_front();
      n_done += int'(done_a);
      n_checks++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL one_shot cyc %0d: got %h required %h", c, obs, expv);
      end
    end
    n_checks++;
    if (n_done !== 1 || step_a !== 4'd15 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL one_shot_end: got done_count=%0d step=%0d busy=%b required 1 15 0",
               n_done, step_a, busy_a);
    end
    restart = 1'b1;
    advance();
    restart = 1'b0;
    expv = exp_q.pop_front();
    n_checks++;
    if (obs !== expv || step_a !== 4'd0 || busy_a !== 1'b1) begin
      n_fail++; $display("FAIL one_shot_restart: got %h required %h", obs, expv);
    end
  endtask

  task automatic test_loop();
    hold_len = 4'd0; loop_en = 1'b1; play = 1'b1; pingpong = 1'b0; restart = 1'b1;
    for (int c = 0; c < 25; c++) begin
      advance();
      restart = 1'b0;
      expv = exp_q.pop_front();
      n_checks++;
      if (obs !== expv || step_b > 4'd9) begin
        n_fail++; $display("FAIL loop cyc %0d: got %h required %h", c, obs, expv);
      end
    end
  endtask

  task automatic test_pause();
    int guard = 0;
    hold_len = 4'd2; loop_en = 1'b1; play = 1'b1; restart = 1'b1;
    advance();
    restart = 1'b0;
    void'(exp_q.pop_front());
    while (!(mdl[0].state == S_PLAY && mdl[0].step == 5 && mdl[0].cnt == 1) && guard < 100) begin
      advance();
      guard++;
      expv = exp_q.pop_front();
      n_checks++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL pause_lead cyc %0d: got %h required %h", guard, obs, expv);
      end
    end
    if (guard >= 100) begin
      n_fail++; $display("FAIL pause_reach: got timeout required step 5");
    end
    play = 1'b0;
    for (int c = 0; c < 20; c++) begin
      advance();
      expv = exp_q.pop_front();
      n_checks++;
      if (obs !== expv || step_a !== 4'd5) begin
        n_fail++; $display("FAIL pause_hold cyc %0d: got %h required %h", c, obs, expv);
      end
    end
    play = 1'b1;
    for (int c = 0; c < 6; c++) begin
      advance();
      expv = exp_q.pop_front();
      n_checks++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL pause_resume cyc %0d: got %h required %h", c, obs, expv);
      end
    end
  endtask

  task automatic test_pingpong();
    hold_len = 4'd0; loop_en = 1'b1; play = 1'b1; pingpong = 1'b1; restart = 1'b1;
    for (int c = 0; c < 24; c++) begin
      if (c == 14) pingpong = 1'b0;
      advance();
      restart = 1'b0;
      expv = exp_q.pop_front();
      n_checks++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL pingpong cyc %0d: got %h required %h", c, obs, expv);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 300; c++) begin
      play     = ($urandom_range(0, 3) != 0);
      restart  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) loop_en = ~loop_en;
      if ($urandom_range(0, 9) == 0) pingpong = ~pingpong;
      hold_len = 4'($urandom_range(0, 3));
      advance();
      expv = exp_q.pop_front();
      n_checks++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL random cyc %0d: got %h required %h", c, obs, expv);
      end
    end
    restart = 1'b0;
  endtask

  initial begin
    test_reset();
    test_hold();
    test_one_shot();
    test_loop();
    test_pause();
    test_pingpong();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "bench timeout");
  end

endmodule

`default_nettype wire
